// File: rtl/nano_rv32i_pkg.sv
// Shared nano_rv32i definitions: branch funct3 codes, ALU op encodings and the
// branch_ctrl FSM state type.
package nano_rv32i_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  typedef enum logic [2:0] {
    StIdle,
    StCmp,
    StEval,
    StRedirect,
    StResp
  } branch_ctrl_state_t;

  // 010/011 are unassigned branch encodings in RV32I.
  function automatic logic f3_branch_legal(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  function automatic logic [3:0] f3_alu_op(input logic [2:0] f3);
    case (f3)
      F3_BEQ, F3_BNE:   return ALU_SUB;
      F3_BLT, F3_BGE:   return ALU_SLT;
      F3_BLTU, F3_BGEU: return ALU_SLTU;
      default:          return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Request, shared-ALU, fetch-redirect and completion signals of branch_ctrl.
// The slave modport is the controller side, master is the core/fetch side.
interface branch_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic            is_branch_i;
  logic            is_jal_i;
  logic            is_jalr_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] rs1_i;

  logic            alu_req_o;
  logic [3:0]      alu_op_o;
  logic            alu_gnt_i;
  logic            alu_zero_i;
  logic            alu_lt_i;

  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            redirect_ready_i;
  logic            flush_o;

  logic            done_o;
  logic            taken_o;
  logic            illegal_o;
  logic            misalign_o;
  logic            link_we_o;
  logic [XLEN-1:0] link_data_o;

  modport slave (
    input  req_valid_i, is_branch_i, is_jal_i, is_jalr_i, funct3_i, pc_i, imm_i, rs1_i,
    input  alu_gnt_i, alu_zero_i, alu_lt_i, redirect_ready_i,
    output req_ready_o, alu_req_o, alu_op_o, redirect_valid_o, redirect_pc_o, flush_o,
    output done_o, taken_o, illegal_o, misalign_o, link_we_o, link_data_o
  );

  modport master (
    output req_valid_i, is_branch_i, is_jal_i, is_jalr_i, funct3_i, pc_i, imm_i, rs1_i,
    output alu_gnt_i, alu_zero_i, alu_lt_i, redirect_ready_i,
    input  req_ready_o, alu_req_o, alu_op_o, redirect_valid_o, redirect_pc_o, flush_o,
    input  done_o, taken_o, illegal_o, misalign_o, link_we_o, link_data_o
  );

endinterface

// File: rtl/branch_cond.sv
// Combinational branch taken decision from funct3 and the ALU zero/lt flags.
module branch_cond
  import nano_rv32i_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       lt_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      F3_BEQ:           taken_o = zero_i;
      F3_BNE:           taken_o = ~zero_i;
      F3_BLT, F3_BLTU:  taken_o = lt_i;
      F3_BGE, F3_BGEU:  taken_o = ~lt_i;
      default:          taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Multi-cycle branch/jump resolution: borrows the shared ALU, redirects fetch, reports done.
// Optional BRANCH_CTRL_STATS_EN adds saturating taken/not-taken branch counters.
module branch_ctrl
  import nano_rv32i_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned RESET_PC_ALIGN = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef BRANCH_CTRL_STATS_EN
  output logic [31:0] taken_cnt_o,
  output logic [31:0] not_taken_cnt_o,
`endif
  branch_ctrl_if.slave bus
);

  localparam logic [XLEN-1:0] AlignMask = (XLEN'(1) << RESET_PC_ALIGN) - XLEN'(1);

  branch_ctrl_state_t state_q, state_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [XLEN-1:0]    target_q, target_d;
  logic [XLEN-1:0]    link_q, link_d;
  logic               is_jump_q, is_jump_d;
  logic               taken_q, taken_d;
  logic               illegal_q, illegal_d;
  logic               misalign_q, misalign_d;
  logic               cond_taken;

  branch_cond u_branch_cond (
    .funct3_i (funct3_q),
    .zero_i   (bus.alu_zero_i),
    .lt_i     (bus.alu_lt_i),
    .taken_o  (cond_taken)
  );

  always_comb begin
    state_d    = state_q;
    funct3_d   = funct3_q;
    target_d   = target_q;
    link_d     = link_q;
    is_jump_d  = is_jump_q;
    taken_d    = taken_q;
    illegal_d  = illegal_q;
    misalign_d = misalign_q;

    bus.req_ready_o      = 1'b0;
    bus.alu_req_o        = 1'b0;
    bus.alu_op_o         = 4'b0000;
    bus.redirect_valid_o = 1'b0;
    bus.redirect_pc_o    = '0;
    bus.flush_o          = 1'b0;
    bus.done_o           = 1'b0;
    bus.taken_o          = 1'b0;
    bus.illegal_o        = 1'b0;
    bus.misalign_o       = 1'b0;
    bus.link_we_o        = 1'b0;
    bus.link_data_o      = '0;

    case (state_q)
      StIdle: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) begin
          funct3_d   = bus.funct3_i;
          link_d     = bus.pc_i + XLEN'(4);
          is_jump_d  = bus.is_jal_i | bus.is_jalr_i;
          taken_d    = 1'b0;
          illegal_d  = 1'b0;
          misalign_d = 1'b0;
          target_d   = bus.pc_i + bus.imm_i;
          if (bus.is_jal_i) begin
            taken_d = 1'b1;
            state_d = StRedirect;
          end else if (bus.is_jalr_i) begin
            target_d = (bus.rs1_i + bus.imm_i) & ~XLEN'(1);
            taken_d  = 1'b1;
            state_d  = StRedirect;
          end else if (bus.is_branch_i && f3_branch_legal(bus.funct3_i)) begin
            state_d = StCmp;
          end else begin
            illegal_d = 1'b1;
            state_d   = StResp;
          end
        end
      end
      StCmp: begin
        bus.alu_req_o = 1'b1;
        bus.alu_op_o  = f3_alu_op(funct3_q);
        if (bus.alu_gnt_i) begin
          state_d = StEval;
        end
      end
      StEval: begin
        taken_d = cond_taken;
        state_d = cond_taken ? StRedirect : StResp;
      end
      StRedirect: begin
        if ((target_q & AlignMask) != '0) begin
          // Misaligned target never reaches fetch.
          misalign_d = 1'b1;
          taken_d    = 1'b0;
          state_d    = StResp;
        end else begin
          bus.redirect_valid_o = 1'b1;
          bus.redirect_pc_o    = target_q;
          if (bus.redirect_ready_i) begin
            bus.flush_o = 1'b1;
            state_d     = StResp;
          end
        end
      end
      StResp: begin
        bus.done_o      = 1'b1;
        bus.taken_o     = taken_q;
        bus.illegal_o   = illegal_q;
        bus.misalign_o  = misalign_q;
        bus.link_we_o   = is_jump_q & ~misalign_q;
        bus.link_data_o = link_q;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      funct3_q   <= 3'b000;
      target_q   <= '0;
      link_q     <= '0;
      is_jump_q  <= 1'b0;
      taken_q    <= 1'b0;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      target_q   <= target_d;
      link_q     <= link_d;
      is_jump_q  <= is_jump_d;
      taken_q    <= taken_d;
      illegal_q  <= illegal_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef BRANCH_CTRL_STATS_EN
  logic [31:0] taken_cnt_q, not_taken_cnt_q;
  logic        count_evt;

  // A legal, non-jump request is a conditional branch.
  assign count_evt = (state_q == StResp) && !is_jump_q && !illegal_q && !misalign_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else if (count_evt) begin
      if (taken_q && (taken_cnt_q != 32'hFFFF_FFFF)) begin
        taken_cnt_q <= taken_cnt_q + 32'd1;
      end else if (!taken_q && (not_taken_cnt_q != 32'hFFFF_FFFF)) begin
        not_taken_cnt_q <= not_taken_cnt_q + 32'd1;
      end
    end
  end

  assign taken_cnt_o     = taken_cnt_q;
  assign not_taken_cnt_o = not_taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus randomized requests
// checked against a behavioural model. Covers the BRANCH_CTRL_STATS_EN counters when defined.
module tb_branch_ctrl;
  import nano_rv32i_pkg::*;

  localparam int unsigned XLEN = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  branch_ctrl_if #(.XLEN(XLEN)) bus ();

`ifdef BRANCH_CTRL_STATS_EN
  logic [31:0] taken_cnt;
  logic [31:0] not_taken_cnt;
`endif

  branch_ctrl #(
    .XLEN           (XLEN),
    .RESET_PC_ALIGN (2)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
`ifdef BRANCH_CTRL_STATS_EN
    .taken_cnt_o     (taken_cnt),
    .not_taken_cnt_o (not_taken_cnt),
`endif
    .bus             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction description: kind 0=none, 1=jal, 2=jalr, 3=branch; a/b are the compared operands.
  int          t_kind;
  logic [2:0]  t_f3;
  logic [31:0] t_pc, t_imm, t_rs1, t_a, t_b;
  int          t_gd, t_rd;

  // Observations
  int          o_done, o_flush_cnt, o_flush_cyc;
  logic        o_ready0, o_taken, o_illegal, o_misalign, o_link_we, o_op_bad, o_rpc_bad;
  logic [31:0] o_rpc, o_link;
  logic [3:0]  o_op;
  int          o_alu_reqs;

  // Expectations
  int          e_done, e_flush_cnt;
  logic        e_taken, e_illegal, e_misalign, e_link_we, e_alu;
  logic [31:0] e_target, e_link;
  logic [3:0]  e_op;

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      default:  return 32'h1;
    endcase
  endfunction

  task automatic model();
    logic jump, cond, want;
    e_illegal = (t_kind == 0) || (t_kind == 3 && (t_f3 == 3'b010 || t_f3 == 3'b011));
    jump      = (t_kind == 1) || (t_kind == 2);
    e_target  = (t_kind == 2) ? ((t_rs1 + t_imm) & 32'hFFFF_FFFE) : (t_pc + t_imm);
    case (t_f3)
      3'b000:  cond = (t_a == t_b);
      3'b001:  cond = (t_a != t_b);
      3'b100:  cond = ($signed(t_a) < $signed(t_b));
      3'b101:  cond = ($signed(t_a) >= $signed(t_b));
      3'b110:  cond = (t_a < t_b);
      3'b111:  cond = (t_a >= t_b);
      default: cond = 1'b0;
    endcase
    case (t_f3)
      3'b000, 3'b001: e_op = ALU_SUB;
      3'b100, 3'b101: e_op = ALU_SLT;
      3'b110, 3'b111: e_op = ALU_SLTU;
      default:        e_op = 4'b0000;
    endcase
    e_alu       = (t_kind == 3) && !e_illegal;
    want        = !e_illegal && (jump || cond);
    e_misalign  = want && (e_target[1:0] != 2'b00);
    e_taken     = want && !e_misalign;
    e_link_we   = jump && !e_misalign;
    e_link      = t_pc + 32'd4;
    e_flush_cnt = e_taken ? 1 : 0;
    if (e_illegal)       e_done = 1;
    else if (jump)       e_done = e_misalign ? 2 : 2 + t_rd;
    else if (!cond)      e_done = 3 + t_gd;
    else if (e_misalign) e_done = 4 + t_gd;
    else                 e_done = 4 + t_gd + t_rd;
  endtask

  // Drives one request from an IDLE cycle and plays ALU arbiter and fetch until done_o.
  task automatic run_op();
    int          rv_cnt;
    logic        grant_prev;
    logic [31:0] res;
    @(negedge clk);
    o_ready0          = bus.req_ready_o;
    bus.req_valid_i   = 1'b1;
    bus.is_jal_i      = (t_kind == 1);
    bus.is_jalr_i     = (t_kind == 2);
    bus.is_branch_i   = (t_kind == 3);
    bus.funct3_i      = t_f3;
    bus.pc_i          = t_pc;
    bus.imm_i         = t_imm;
    bus.rs1_i         = t_rs1;
    o_done = -1; o_flush_cnt = 0; o_flush_cyc = -1; o_alu_reqs = 0;
    o_op_bad = 1'b0; o_rpc_bad = 1'b0; o_op = 4'b0000; o_rpc = 32'h0;
    o_taken = 1'b0; o_illegal = 1'b0; o_misalign = 1'b0; o_link_we = 1'b0; o_link = 32'h0;
    rv_cnt = 0; grant_prev = 1'b0;
    for (int k = 1; k <= 60 && o_done < 0; k++) begin
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
      bus.is_jal_i = 1'b0; bus.is_jalr_i = 1'b0; bus.is_branch_i = 1'b0;
      bus.pc_i = $urandom; bus.imm_i = $urandom; bus.rs1_i = $urandom;
      bus.funct3_i = 3'($urandom_range(0, 7));
      // Flags are meaningful only in the cycle after a grant; garbage elsewhere.
      if (grant_prev) begin
        res            = alu_model(o_op, t_a, t_b);
        bus.alu_zero_i = (res == 32'h0);
        bus.alu_lt_i   = res[0];
      end else begin
        bus.alu_zero_i = 1'($urandom_range(0, 1));
        bus.alu_lt_i   = 1'($urandom_range(0, 1));
      end
      grant_prev = 1'b0;
      if (bus.alu_req_o) begin
        if (o_alu_reqs == 0) o_op = bus.alu_op_o;
        else if (bus.alu_op_o !== o_op) o_op_bad = 1'b1;
        o_alu_reqs++;
        bus.alu_gnt_i = (o_alu_reqs > t_gd);
        grant_prev    = bus.alu_gnt_i;
      end else begin
        bus.alu_gnt_i = 1'b0;
      end
      if (bus.redirect_valid_o) begin
        if (rv_cnt == 0) o_rpc = bus.redirect_pc_o;
        else if (bus.redirect_pc_o !== o_rpc) o_rpc_bad = 1'b1;
        rv_cnt++;
        bus.redirect_ready_i = (rv_cnt > t_rd);
      end else begin
        bus.redirect_ready_i = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (bus.flush_o === 1'b1) begin
        o_flush_cnt++;
        o_flush_cyc = k;
      end
      if (bus.done_o === 1'b1) begin
        o_done     = k;
        o_taken    = bus.taken_o;
        o_illegal  = bus.illegal_o;
        o_misalign = bus.misalign_o;
        o_link_we  = bus.link_we_o;
        o_link     = bus.link_data_o;
      end
    end
    bus.alu_gnt_i        = 1'b0;
    bus.redirect_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [76:0] outs;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs = {bus.req_ready_o, bus.alu_req_o, bus.alu_op_o, bus.redirect_valid_o,
            bus.redirect_pc_o, bus.flush_o, bus.done_o, bus.taken_o, bus.illegal_o,
            bus.misalign_o, bus.link_we_o, bus.link_data_o};
    checks++;
    if (outs !== {1'b1, 76'b0}) begin
      failures++; $display("FAIL reset_outputs got=%h want=%h", outs, {1'b1, 76'b0});
    end
`ifdef BRANCH_CTRL_STATS_EN
    checks++;
    if ({taken_cnt, not_taken_cnt} !== 64'h0) begin
      failures++; $display("FAIL reset_counters got=%h/%h want=0/0", taken_cnt, not_taken_cnt);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_jal();
    t_kind = 1; t_f3 = 3'b000; t_pc = 32'h100; t_imm = 32'h20; t_rs1 = 32'h0;
    t_a = 0; t_b = 0; t_gd = 0; t_rd = 0;
    run_op();
    checks++;
    if (o_flush_cyc !== 1) begin failures++; $display("FAIL jal_flush_cycle got=%0d want=1", o_flush_cyc); end
    checks++;
    if (o_rpc !== 32'h120) begin failures++; $display("FAIL jal_redirect_pc got=%h want=00000120", o_rpc); end
    checks++;
    if (o_done !== 2) begin failures++; $display("FAIL jal_done_cycle got=%0d want=2", o_done); end
    checks++;
    if ({o_link_we, o_link} !== {1'b1, 32'h104}) begin
      failures++; $display("FAIL jal_link got=%b/%h want=1/00000104", o_link_we, o_link);
    end
  endtask

  task automatic test_beq();
    t_kind = 3; t_f3 = F3_BEQ; t_pc = 32'h200; t_imm = 32'hFFFF_FFF8; t_rs1 = 32'h0;
    t_a = 32'd7; t_b = 32'd7; t_gd = 0; t_rd = 0;
    run_op();
    checks++;
    if (o_flush_cyc !== 3 || o_rpc !== 32'h1F8) begin
      failures++; $display("FAIL beq_taken_redirect got=cyc%0d/%h want=cyc3/000001f8", o_flush_cyc, o_rpc);
    end
    checks++;
    if (o_done !== 4 || o_taken !== 1'b1) begin
      failures++; $display("FAIL beq_taken_done got=%0d/%b want=4/1", o_done, o_taken);
    end
    t_b = 32'd8;
    run_op();
    checks++;
    if (o_flush_cnt !== 0) begin failures++; $display("FAIL beq_nt_flush got=%0d want=0", o_flush_cnt); end
    checks++;
    if (o_done !== 3 || o_taken !== 1'b0) begin
      failures++; $display("FAIL beq_nt_done got=%0d/%b want=3/0", o_done, o_taken);
    end
  endtask

  task automatic test_bltu_stall();
    t_kind = 3; t_f3 = F3_BLTU; t_pc = 32'h300; t_imm = 32'h40; t_rs1 = 32'h0;
    t_a = 32'd1; t_b = 32'hFFFF_0000; t_gd = 3; t_rd = 2;
    run_op();
    checks++;
    if (o_op !== ALU_SLTU || o_op_bad !== 1'b0 || o_alu_reqs !== 4) begin
      failures++; $display("FAIL bltu_alu_op got=%h/bad%b/reqs%0d want=%h/bad0/reqs4", o_op, o_op_bad, o_alu_reqs, ALU_SLTU);
    end
    checks++;
    if (o_done !== 9) begin failures++; $display("FAIL bltu_done_cycle got=%0d want=9", o_done); end
    checks++;
    if (o_flush_cnt !== 1 || o_rpc_bad !== 1'b0 || o_rpc !== 32'h340) begin
      failures++; $display("FAIL bltu_flush got=%0d/bad%b/%h want=1/bad0/00000340", o_flush_cnt, o_rpc_bad, o_rpc);
    end
  endtask

  task automatic test_jalr_misalign();
    t_kind = 2; t_f3 = 3'b000; t_pc = 32'h80; t_imm = 32'h2; t_rs1 = 32'h1001;
    t_a = 0; t_b = 0; t_gd = 0; t_rd = 0;
    run_op();
    checks++;
    if ({o_misalign, o_taken, o_link_we} !== 3'b100) begin
      failures++; $display("FAIL jalr_misalign_flags got=%b%b%b want=100", o_misalign, o_taken, o_link_we);
    end
    checks++;
    if (o_flush_cnt !== 0 || o_done !== 2) begin
      failures++; $display("FAIL jalr_misalign_timing got=flush%0d/done%0d want=flush0/done2", o_flush_cnt, o_done);
    end
  endtask

  task automatic test_illegal();
    t_kind = 3; t_f3 = 3'b010; t_pc = 32'h40; t_imm = 32'h8; t_rs1 = 32'h0;
    t_a = 0; t_b = 0; t_gd = 0; t_rd = 0;
    run_op();
    checks++;
    if (o_done !== 1 || o_illegal !== 1'b1 || o_taken !== 1'b0) begin
      failures++; $display("FAIL illegal_f3 got=done%0d/%b/%b want=done1/1/0", o_done, o_illegal, o_taken);
    end
    t_kind = 0; t_f3 = F3_BEQ;
    run_op();
    checks++;
    if (o_done !== 1 || o_illegal !== 1'b1 || o_alu_reqs !== 0) begin
      failures++; $display("FAIL illegal_noclass got=done%0d/%b/reqs%0d want=done1/1/reqs0", o_done, o_illegal, o_alu_reqs);
    end
  endtask

  // Back-to-back random requests: each starts in the cycle after the previous done_o.
  task automatic test_random();
    int          sel;
    logic [31:0] r;
    for (int n = 0; n < 150; n++) begin
      sel    = $urandom_range(0, 9);
      t_kind = (sel == 0) ? 0 : (sel <= 2) ? 1 : (sel <= 4) ? 2 : 3;
      t_f3   = 3'($urandom_range(0, 7));
      t_pc   = $urandom & 32'hFFFF_FFFC;
      r      = $urandom;
      t_imm  = ($urandom_range(0, 3) == 0) ? r : (r & 32'hFFFF_FFFC);
      t_rs1  = $urandom;
      t_a    = $urandom;
      t_b    = ($urandom_range(0, 3) == 0) ? t_a : $urandom;
      t_gd   = $urandom_range(0, 3);
      t_rd   = $urandom_range(0, 3);
      model();
      run_op();
      checks++;
      if (o_ready0 !== 1'b1) begin failures++; $display("FAIL rnd%0d_ready got=%b want=1", n, o_ready0); end
      checks++;
      if (o_done !== e_done) begin failures++; $display("FAIL rnd%0d_done_cycle got=%0d want=%0d", n, o_done, e_done); end
      checks++;
      if ({o_taken, o_illegal, o_misalign, o_link_we} !== {e_taken, e_illegal, e_misalign, e_link_we}) begin
        failures++;
        $display("FAIL rnd%0d_flags got=%b%b%b%b want=%b%b%b%b", n, o_taken, o_illegal, o_misalign,
                 o_link_we, e_taken, e_illegal, e_misalign, e_link_we);
      end
      checks++;
      if (o_flush_cnt !== e_flush_cnt) begin
        failures++; $display("FAIL rnd%0d_flush_count got=%0d want=%0d", n, o_flush_cnt, e_flush_cnt);
      end
      if (e_taken) begin
        checks++;
        if (o_rpc !== e_target || o_rpc_bad !== 1'b0 || o_flush_cyc !== e_done - 1) begin
          failures++;
          $display("FAIL rnd%0d_redirect got=%h/bad%b/cyc%0d want=%h/bad0/cyc%0d", n, o_rpc, o_rpc_bad,
                   o_flush_cyc, e_target, e_done - 1);
        end
      end
      if (e_link_we) begin
        checks++;
        if (o_link !== e_link) begin failures++; $display("FAIL rnd%0d_link got=%h want=%h", n, o_link, e_link); end
      end
      checks++;
      if (e_alu ? (o_op !== e_op || o_op_bad !== 1'b0 || o_alu_reqs !== t_gd + 1) : (o_alu_reqs !== 0)) begin
        failures++;
        $display("FAIL rnd%0d_alu got=%h/bad%b/reqs%0d want=%h/reqs%0d", n, o_op, o_op_bad, o_alu_reqs,
                 e_op, e_alu ? t_gd + 1 : 0);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic saw_done;
    @(negedge clk);
    bus.is_jal_i = 1'b1; bus.is_jalr_i = 1'b0; bus.is_branch_i = 1'b0;
    bus.pc_i = 32'h400; bus.imm_i = 32'h10; bus.req_valid_i = 1'b1; bus.redirect_ready_i = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0; bus.is_jal_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.redirect_valid_o !== 1'b1) begin
      failures++; $display("FAIL abort_redirect_active got=%b want=1", bus.redirect_valid_o);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.redirect_valid_o, bus.req_ready_o, bus.done_o, bus.flush_o} !== 4'b0100) begin
      failures++;
      $display("FAIL abort_state got=%b%b%b%b want=0100", bus.redirect_valid_o, bus.req_ready_o,
               bus.done_o, bus.flush_o);
    end
    saw_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1 || bus.flush_o === 1'b1 || bus.redirect_valid_o === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin failures++; $display("FAIL abort_no_completion got=%b want=0", saw_done); end
  endtask

`ifdef BRANCH_CTRL_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      t_kind = 3; t_f3 = F3_BEQ; t_pc = 32'h500; t_imm = 32'h10; t_rs1 = 32'h0;
      t_a = 32'd5; t_b = (i < 3) ? 32'd5 : 32'd6; t_gd = 0; t_rd = 0;
      run_op();
    end
    // Jumps, illegal and misaligned requests must not count.
    t_kind = 1; t_imm = 32'h10; run_op();
    t_kind = 0; run_op();
    t_kind = 3; t_a = 32'd5; t_b = 32'd5; t_imm = 32'h12; run_op();
    @(negedge clk);
    checks++;
    if (taken_cnt !== 32'd3 || not_taken_cnt !== 32'd2) begin
      failures++; $display("FAIL stats_counts got=%0d/%0d want=3/2", taken_cnt, not_taken_cnt);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.req_valid_i = 1'b0; bus.is_branch_i = 1'b0; bus.is_jal_i = 1'b0; bus.is_jalr_i = 1'b0;
    bus.funct3_i = 3'b000; bus.pc_i = 32'h0; bus.imm_i = 32'h0; bus.rs1_i = 32'h0;
    bus.alu_gnt_i = 1'b0; bus.alu_zero_i = 1'b0; bus.alu_lt_i = 1'b0; bus.redirect_ready_i = 1'b0;
    test_reset();
    test_jal();
    test_beq();
    test_bltu_stall();
    test_jalr_misalign();
    test_illegal();
    test_random();
    test_reset_abort();
`ifdef BRANCH_CTRL_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
